n_any_gate: RTL and testbench

- Parameterised N-input selectable logic gate, registered.
- Reduces an N-bit input vector with one of four operations (AND, XOR, XNOR, OR), chosen by a 2-bit select.
- The result is registered on the clock with a valid flag.
- Generic glue-logic primitive for control paths: parity, all-ones detect, any-set detect.

---
 rtl/n_any_gate_pkg.sv | 14 +
 rtl/n_any_gate_reduce.sv | 23 ++
 rtl/n_any_gate.sv | 52 +++++
 tb/tb_n_any_gate.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/n_any_gate_pkg.sv
// Shared definitions for the selectable N-input reduction gate.
// Select encodings and their width are used by the top and the reduction core.
package n_any_gate_pkg;

    localparam int GATE_SEL_W = 2;

    typedef enum logic [GATE_SEL_W-1:0] {
        GATE_AND  = 2'b00,
        GATE_XOR  = 2'b01,
        GATE_XNOR = 2'b10,
        GATE_OR   = 2'b11
    } gate_sel_e;

endpackage

// File: rtl/n_any_gate_reduce.sv
// Combinational core: reduces all N input bits with the selected operation.
// Every select encoding is meaningful, so the case is full without a default.
module n_any_gate_reduce
    import n_any_gate_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]          gate_in_i,
    input  logic [GATE_SEL_W-1:0] gate_select_i,
    output logic                  result_o
);

    always_comb begin
        result_o = 1'b0;
        case (gate_sel_e'(gate_select_i))
            GATE_AND:  result_o = &gate_in_i;
            GATE_XOR:  result_o = ^gate_in_i;
            GATE_XNOR: result_o = ~^gate_in_i;
            GATE_OR:   result_o = |gate_in_i;
        endcase
    end

endmodule

// File: rtl/n_any_gate.sv
// Registered N-input selectable gate with a one-cycle valid flag.
// The result register holds its value between accepted samples; only the flag drops.
module n_any_gate
    import n_any_gate_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [N-1:0]          gate_in,
    input  logic [GATE_SEL_W-1:0] gate_select,
    output logic                  gate_out,
    output logic                  out_valid
);

    logic reduce_result;
    logic gate_out_q;
    logic gate_out_d;
    logic out_valid_q;
    logic out_valid_d;

    n_any_gate_reduce #(
        .N (N)
    ) u_reduce (
        .gate_in_i     (gate_in),
        .gate_select_i (gate_select),
        .result_o      (reduce_result)
    );

    always_comb begin
        gate_out_d  = gate_out_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            gate_out_d = reduce_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gate_out_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            gate_out_q  <= gate_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign gate_out  = gate_out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_n_any_gate.sv
// Bench for n_any_gate: four instances (N=1,2,7,8) driven in lockstep and
// compared every cycle with a population-count reference model.
module tb_n_any_gate;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] gate_select;
    logic [0:0] gi1;
    logic [1:0] gi2;
    logic [6:0] gi7;
    logic [7:0] gi8;
    logic       go1, go2, go7, go8;
    logic       ov1, ov2, ov7, ov8;

    int total = 0;
    int bad   = 0;

    int   nw [4] = '{1, 2, 7, 8};
    logic exp_out [4];
    logic exp_val [4];

    n_any_gate #(.N(1)) dut1 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gate_in(gi1),
                              .gate_select(gate_select), .gate_out(go1), .out_valid(ov1));
    n_any_gate #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gate_in(gi2),
                              .gate_select(gate_select), .gate_out(go2), .out_valid(ov2));
    n_any_gate #(.N(7)) dut7 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gate_in(gi7),
                              .gate_select(gate_select), .gate_out(go7), .out_valid(ov7));
    n_any_gate #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gate_in(gi8),
                              .gate_select(gate_select), .gate_out(go8), .out_valid(ov8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    // Reference: count the ones, then apply the rule for the selected operation.
    function automatic logic ref_gate(input logic [7:0] v, input int n, input logic [1:0] sel);
        int ones;
        ones = $countones(v);
        case (sel)
            2'b00:   return ones == n;
            2'b01:   return (ones % 2) == 1;
            2'b10:   return (ones % 2) == 0;
            default: return ones != 0;
        endcase
    endfunction

    function automatic logic [7:0] in_of(input int i);
        case (i)
            0:       return {7'd0, gi1};
            1:       return {6'd0, gi2};
            2:       return {1'b0, gi7};
            default: return gi8;
        endcase
    endfunction

    function automatic logic out_of(input int i, input bit want_valid);
        case (i)
            0:       return want_valid ? ov1 : go1;
            1:       return want_valid ? ov2 : go2;
            2:       return want_valid ? ov7 : go7;
            default: return want_valid ? ov8 : go8;
        endcase
    endfunction

    // Predict from the inputs present at the edge, clock, then compare all instances.
    task automatic cycle(input string tag);
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                exp_out[i] = 1'b0;
                exp_val[i] = 1'b0;
            end else if (in_valid) begin
                exp_out[i] = ref_gate(in_of(i), nw[i], gate_select);
                exp_val[i] = 1'b1;
            end else begin
                exp_val[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s_N%0d_out", tag, nw[i]), out_of(i, 1'b0), exp_out[i]);
            check($sformatf("%s_N%0d_val", tag, nw[i]), out_of(i, 1'b1), exp_val[i]);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] val);
        in_valid    = v;
        gate_select = sel;
        gi1         = val[0:0];
        gi2         = val[1:0];
        gi7         = val[6:0];
        gi8         = val;
    endtask

    logic [3:0] tbl2 [4];
    logic [3:0] tbl8_ff;
    logic [3:0] tbl8_01;
    logic [31:0] r;

    initial begin
        // Expected bits indexed by select {OR,XNOR,XOR,AND} for N=2 inputs 00..11.
        tbl2[0] = 4'b0100;
        tbl2[1] = 4'b1010;
        tbl2[2] = 4'b1010;
        tbl2[3] = 4'b1101;
        tbl8_ff = 4'b1101;
        tbl8_01 = 4'b1010;

        rst_n = 1'b0;
        drive(1'b1, 2'b00, 8'hFF);
        for (int c = 0; c < 2; c++) begin
            cycle("reset");
            check("reset_out2", go2, 1'b0);
            check("reset_val2", ov2, 1'b0);
        end
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            for (int s = 0; s < 4; s++) begin
                drive(1'b1, s[1:0], {6'd0, v[1:0]});
                cycle("exh");
                check($sformatf("exh_tbl_in%0d_sel%0d", v, s), go2, tbl2[v][s]);
            end
        end

        drive(1'b1, 2'b00, 8'hFF);
        cycle("hold_load");
        check("hold_load_out2", go2, 1'b1);
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 2'b00, 8'h00);
            cycle("hold");
            check("hold_out2", go2, 1'b1);
            check("hold_val2", ov2, 1'b0);
        end

        drive(1'b1, 2'b11, 8'hFF);
        cycle("mid1");
        rst_n = 1'b0;
        drive(1'b1, 2'b11, 8'h55);
        cycle("mid2");
        check("mid_rst_out2", go2, 1'b0);
        check("mid_rst_val2", ov2, 1'b0);
        rst_n = 1'b1;
        drive(1'b1, 2'b01, 8'h01);
        cycle("mid3");
        check("mid_resume_out2", go2, 1'b1);
        check("mid_resume_val2", ov2, 1'b1);

        for (int s = 0; s < 4; s++) begin
            drive(1'b1, s[1:0], 8'hFF);
            cycle("wideff");
            check($sformatf("wide_ff_sel%0d", s), go8, tbl8_ff[s]);
            drive(1'b1, s[1:0], 8'h01);
            cycle("wide01");
            check($sformatf("wide_01_sel%0d", s), go8, tbl8_01[s]);
        end

        for (int c = 0; c < 1000; c++) begin
            r = $urandom;
            rst_n = (r[31:26] != 6'd0);
            drive(r[8], r[10:9], r[7:0]);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
